sp_ram_arbiter: RTL
===================

// Module: sp_ram_arbiter
// PURPOSE
//   Shares one single-port RAM (sp_ram_wrap, 1-cycle read latency) between two
//   masters using a req/gnt/rvalid handshake. Typical use: instruction fetch on
//   port 0 and data/debug traffic on port 1, both targeting one RAM instance.
//   Grants at most one access per cycle with round-robin fairness.
//   Routes the registered response (rvalid/rdata) back to the granted master.
// PARAMETERS
//   ADDR_WIDTH  15  width of byte address passed unchanged to the RAM
//   DATA_WIDTH  32  data width; byte-enable width is DATA_WIDTH/8
// PORTS
//   clk          in   1         clock
//   rstn_i       in   1         asynchronous active-low reset
//   pN_req_i     in   1         (N=0,1) access request; hold stable until granted
//   pN_gnt_o     out  1         access accepted this cycle
//   pN_addr_i    in   ADDR_WIDTH byte address
//   pN_we_i      in   1         1=write, 0=read
//   pN_be_i      in   DW/8      byte enables
//   pN_wdata_i   in   DW        write data
//   pN_rvalid_o  out  1         response for the access granted in the previous cycle
//   pN_rdata_o   out  DW        read data, qualified by pN_rvalid_o
//   ram_en_o     out  1         RAM access strobe
//   ram_addr_o   out  ADDR_WIDTH RAM address
//   ram_we_o     out  1         RAM write enable, gated by ram_en_o
//   ram_be_o     out  DW/8      RAM byte enables
//   ram_wdata_o  out  DW        RAM write data
//   ram_rdata_i  in   DW        RAM read data, valid the cycle after ram_en_o
// BEHAVIOUR
//   State: prio_q (1 bit, next port to win a tie); rv_q[1:0] (one-hot response
//     owner). Reset (async, rstn_i=0): prio_q=0, rv_q=0.
//   While rstn_i=0: all gnt_o, ram_en_o, ram_we_o and rvalid_o are 0.
//   Grant (combinational, same cycle as req):
//     - only pN_req_i=1 -> gnt to N
//     - both req -> gnt to port prio_q; other port waits, no gnt
//     - neither -> no gnt, ram_en_o=0
//   prio_q <= ~N after every grant to port N. Uncontested grants also update it.
//   ram_en_o = p0_gnt_o | p1_gnt_o. The addr/we/be/wdata mux selects the granted
//     port; when idle, the mux selects port 0 and ram_we_o=0.
//   Response: rv_q <= {p1_gnt_o, p0_gnt_o} every cycle; pN_rvalid_o = rv_q[N].
//     Reads and writes both return exactly one rvalid, 1 cycle after gnt.
//   p0_rdata_o = p1_rdata_o = ram_rdata_i (broadcast); only rvalid qualifies it.
//     Write responses carry don't-care rdata.
//   Throughput: one access per cycle; back-to-back grants to the same or
//     alternating ports are allowed with no bubble.
//   Boundaries:
//     - be=0 write: still granted, ram_we_o=1 with be=0, rvalid returned.
//     - Requester drops req before gnt: no access, no rvalid.
//     - Reset asserted with an access outstanding: its rvalid is dropped.
//     - prio_q never changes on a cycle with no grant.
// TESTING
//   1. p0 read 0x0010 alone -> p0_gnt same cycle, ram_en=1, addr=0x0010, we=0;
//      next cycle p0_rvalid=1, p0_rdata=RAM[0x0010].
//   2. p1 writes 0xDEADBEEF be=4'b0011 @0x0020, then p1 reads it ->
//      rdata[15:0]=0xBEEF, upper bytes keep their previous value.
//   3. Both req continuously for 6 cycles from reset -> grants go p0,p1,p0,p1,p0,p1;
//      each rvalid lands on the matching port 1 cycle later.
//   4. p0 streams 4 back-to-back reads, p1 idle -> 4 gnts in 4 cycles,
//      4 rvalids in the next 4 cycles, no bubbles.
//   5. Pull rstn_i low the cycle after a grant -> that rvalid is never seen;
//      after release, prio_q=0, so p0 wins a tie.
//   6. be=4'b0000 write from p0 -> gnt and rvalid occur; a readback is unchanged.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// Two-master front end for one single-port RAM with a 1-cycle read latency.
// Grants one access per cycle, alternates ties round-robin and routes the response to the winner.
module sp_ram_arbiter #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rstn_i,

   input  logic                    p0_req_i,
   output logic                    p0_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
   input  logic                    p0_we_i,
   input  logic [DATA_WIDTH/8-1:0] p0_be_i,
   input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
   output logic                    p0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p0_rdata_o,

   input  logic                    p1_req_i,
   output logic                    p1_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
   input  logic                    p1_we_i,
   input  logic [DATA_WIDTH/8-1:0] p1_be_i,
   input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
   output logic                    p1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p1_rdata_o,

   output logic                    ram_en_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic                    ram_we_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

   logic       prio_q;
   logic [1:0] rv_q;
   logic       gnt0;
   logic       gnt1;

   // Grants are forced low while reset is held so nothing reaches the RAM.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rstn_i) begin
         if (p0_req_i && p1_req_i) begin
            gnt0 = ~prio_q;
            gnt1 = prio_q;
         end else begin
            gnt0 = p0_req_i;
            gnt1 = p1_req_i;
         end
      end
   end

   assign p0_gnt_o    = gnt0;
   assign p1_gnt_o    = gnt1;

   assign ram_en_o    = gnt0 | gnt1;
   assign ram_addr_o  = gnt1 ? p1_addr_i  : p0_addr_i;
   assign ram_be_o    = gnt1 ? p1_be_i    : p0_be_i;
   assign ram_wdata_o = gnt1 ? p1_wdata_i : p0_wdata_i;
   assign ram_we_o    = ram_en_o & (gnt1 ? p1_we_i : p0_we_i);

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         prio_q <= 1'b0;
         rv_q   <= 2'b00;
      end else begin
         rv_q <= {gnt1, gnt0};
         if (gnt0) begin
            prio_q <= 1'b1;
         end else if (gnt1) begin
            prio_q <= 1'b0;
         end
      end
   end

   assign p0_rvalid_o = rv_q[0];
   assign p1_rvalid_o = rv_q[1];
   assign p0_rdata_o  = ram_rdata_i;
   assign p1_rdata_o  = ram_rdata_i;

endmodule
